life_ctrl: RTL
==============

# life_ctrl

Sequencer for the 8x8 Game of Life cell matrix. Accepts a row-serial seed pattern, loads it into the matrix, then issues paced generation-step pulses. It counts generations and halts automatically on extinction, still life, or (optionally) period-2 oscillation. Sits between the host/test interface and the cell matrix; it is the only source of the matrix's load and step strobes.

## Interface
- N, 8, grid edge length; grid is N*N cells, bit index r*N+c
- PACE, 4, clk cycles between step pulses in RUN; legal minimum 2
- GEN_W, 16, generation counter width
- clk  in  1  single clock, rising edge
- _rst  in  1  synchronous reset, active-low; sampled on clk rising edge
- cmd_start  in  1  enter RUN from IDLE/PAUSE/HALT
- cmd_pause  in  1  RUN -> PAUSE
- cmd_step  in  1  in PAUSE: execute exactly one generation
- cmd_clear  in  1  any state -> IDLE; clear seed shadow and gen_count
- ld_valid  in  1  seed row valid
- ld_ready  out  1  high only in IDLE
- ld_row  in  $clog2(N)  seed row index
- ld_data  in  N  seed row bits, bit c = column c
- grid_q  in  N*N  current matrix state
- seed  out  N*N  seed shadow register, drives matrix load data
- seed_we  out  1  one-cycle matrix load strobe
- step_en  out  1  one-cycle generation strobe
- gen_count  out  GEN_W  completed generations since load
- state  out  3  IDLE=0, RUN=1, PAUSE=2, HALT=3
- halt_cause  out  2  0 none, 1 extinct, 2 still, 3 period-2

## Operation
- Reset (_rst=0 at edge): state IDLE, seed=0, seed_we=0, step_en=0, gen_count=0, halt_cause=0, snapshots=0, pace counter=0.
- IDLE: ld_ready=1; handshake completes when ld_valid&ld_ready at edge; seed[ld_row] <= ld_data. Rows may be written in any order and rewritten. cmd_start: seed_we pulses, gen_count<=0, halt_cause<=0, go RUN.
- RUN: pace counter counts 0..PACE-1; step_en pulses when counter==PACE-1. After each step, evaluate (see Timing) and increment gen_count (saturating at all-ones, no halt on saturation).
- Halt checks, priority order: grid_q==0 -> extinct; grid_q==prev -> still; with macro, grid_q==prev2 -> period-2. A hit sets halt_cause and enters HALT.
- PAUSE: no step_en except one pulse per cmd_step; same evaluation applies, including halt. cmd_start resumes RUN with pace counter restarted at 0.
- HALT: all strobes idle; cmd_start resumes RUN from the current grid without reloading, halt_cause<=0.
- Command priority in the same cycle: cmd_clear > cmd_pause > cmd_step > cmd_start. Commands illegal in the current state are ignored.
- cmd_clear or reset mid-step: any pending evaluation is discarded; matrix contents are untouched.

## Timing
- seed_we asserted the cycle after the cmd_start edge; the matrix shows the seed on grid_q one cycle after seed_we.
- First step_en in RUN occurs no earlier than 2 cycles after seed_we.
- step_en at cycle t -> new generation on grid_q at t+1 -> compare at t+1 edge -> gen_count and halt_cause visible at t+2; state HALT visible at t+2.
- Snapshot prev (and prev2) captured from grid_q at the edge of the step cycle t (pre-step value).
- cmd_step in PAUSE: step_en the next cycle; further cmd_step is ignored until the evaluation completes (2 cycles).
- cmd_pause arriving the same cycle as step_en: the pulse still issues, its evaluation completes, then PAUSE.

## Configuration
- LIFE_CTRL_PERIOD2_EN defined: second snapshot register prev2, period-2 halt detection, halt_cause=3 reachable.
- Undefined: no prev2 storage; blinkers and other oscillators run until paused or cleared; halt_cause never 3.

## Structure
- Package life_pkg: state enum (IDLE/RUN/PAUSE/HALT), halt_cause encoding, N default, grid bit-index helper function.
- Sub-module life_pace: parameterised PACE counter with restart/enable, emitting the step tick.

## Test plan
- Reset mid-RUN at gen 5 -> next cycle state=0, gen_count=0, seed=0, no strobes.
- Load single cell at (4,4), start -> first evaluation: halt_cause=1, gen_count=1, state=HALT.
- Load 2x2 block at rows 2-3 cols 2-3, start -> halt_cause=2, gen_count=1.
- Blinker at row 3, cols 2-4, macro on -> halt_cause=3 at gen_count=2; macro off -> gen_count reaches 10, cmd_pause -> state=2.
- Glider seed, PACE=4 -> step_en exactly every 4 cycles; cmd_pause during RUN, then 3x cmd_step -> gen_count += 3, one step_en each.
- ld_valid held with state RUN -> ld_ready=0, seed unchanged; cmd_clear -> ld_ready=1 and the row is accepted the next cycle.

Source files
------------

// File: rtl/life_pkg.sv
// Shared types and helpers for the Game of Life sequencer:
// FSM state encoding, halt-cause encoding and grid bit-index helper.
package life_pkg;

    localparam int N_DEF = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_PAUSE = 3'd2,
        ST_HALT  = 3'd3
    } life_state_e;

    typedef enum logic [1:0] {
        HC_NONE    = 2'd0,
        HC_EXTINCT = 2'd1,
        HC_STILL   = 2'd2,
        HC_PERIOD2 = 2'd3
    } halt_cause_e;

    // Row-major flat index of cell (r, c) in an n-wide grid.
    function automatic int cell_idx(input int r, input int c, input int n);
        return r * n + c;
    endfunction

endpackage

// File: rtl/life_pace.sv
// Step pacing counter: counts 0..PACE-1 while enabled and flags the last count.
// A restart forces the count back to 0 so a resumed run gets a full interval.
module life_pace #(
    parameter int PACE = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_restart,
    input  logic i_en,
    output logic o_tick
);

    localparam int            CW   = (PACE > 1) ? $clog2(PACE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PACE - 1);

    logic [CW-1:0] r_cnt;

    assign o_tick = i_en && (r_cnt == LAST);

    // Wrapping pace count, held while disabled.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_restart) begin
            r_cnt <= '0;
        end else if (i_en) begin
            if (r_cnt == LAST) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/life_ctrl.sv
// Game of Life sequencer: seed loading, paced generation strobes, generation
// counting and automatic halt. Define LIFE_CTRL_PERIOD2_EN for period-2 halt detection.
module life_ctrl
    import life_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int PACE  = 4,
    parameter int GEN_W = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_cmd_start,
    input  logic                 i_cmd_pause,
    input  logic                 i_cmd_step,
    input  logic                 i_cmd_clear,
    input  logic                 i_ld_valid,
    output logic                 o_ld_ready,
    input  logic [$clog2(N)-1:0] i_ld_row,
    input  logic [N-1:0]         i_ld_data,
    input  logic [N*N-1:0]       i_grid_q,
    output logic [N*N-1:0]       o_seed,
    output logic                 o_seed_we,
    output logic                 o_step_en,
    output logic [GEN_W-1:0]     o_gen_count,
    output logic [2:0]           o_state,
    output logic [1:0]           o_halt_cause
);

    localparam int IW = $clog2(N * N);

    life_state_e      r_state;
    halt_cause_e      r_cause;
    logic [N*N-1:0]   r_seed;
    logic [N*N-1:0]   r_prev;
`ifdef LIFE_CTRL_PERIOD2_EN
    logic [N*N-1:0]   r_prev2;
`endif
    logic [GEN_W-1:0] r_gen;
    logic             r_seed_we;
    logic             r_step_en;
    logic             r_eval_pend;
    logic             r_pause_pend;
    logic             r_ld_ready;

    halt_cause_e      w_hit_cause;
    logic             w_halt_hit;
    logic             w_busy;
    logic             w_pause_req;
    logic             w_start_ok;
    logic             w_tick;
    logic [IW-1:0]    w_row_base;

    assign w_row_base  = IW'(cell_idx(int'(i_ld_row), 0, N));
    assign w_busy      = r_step_en || r_eval_pend;
    assign w_pause_req = i_cmd_pause || r_pause_pend;
    assign w_halt_hit  = r_eval_pend && (w_hit_cause != HC_NONE);

    life_pace #(
        .PACE      (PACE)
    ) u_pace (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_restart (w_start_ok),
        .i_en      (r_state == ST_RUN),
        .o_tick    (w_tick)
    );

    // Halt classification of the freshly stepped grid, highest priority first.
    always_comb begin
        w_hit_cause = HC_NONE;
        if (i_grid_q == '0) begin
            w_hit_cause = HC_EXTINCT;
        end else if (i_grid_q == r_prev) begin
            w_hit_cause = HC_STILL;
`ifdef LIFE_CTRL_PERIOD2_EN
        end else if (i_grid_q == r_prev2) begin
            w_hit_cause = HC_PERIOD2;
`endif
        end else begin
            w_hit_cause = HC_NONE;
        end
    end

    // Start acceptance; a pending step or evaluation in PAUSE blocks it.
    always_comb begin
        w_start_ok = 1'b0;
        if (i_cmd_clear) begin
            w_start_ok = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_HALT: w_start_ok = i_cmd_start;
                ST_PAUSE:         w_start_ok = i_cmd_start && !i_cmd_step && !w_busy;
                default:          w_start_ok = 1'b0;
            endcase
        end
    end

    // Sequencer FSM with its registered strobes, counters and snapshots.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state      <= ST_IDLE;
            r_cause      <= HC_NONE;
            r_seed       <= '0;
            r_prev       <= '0;
`ifdef LIFE_CTRL_PERIOD2_EN
            r_prev2      <= '0;
`endif
            r_gen        <= '0;
            r_seed_we    <= 1'b0;
            r_step_en    <= 1'b0;
            r_eval_pend  <= 1'b0;
            r_pause_pend <= 1'b0;
            r_ld_ready   <= 1'b1;
        end else if (i_cmd_clear) begin
            r_state      <= ST_IDLE;
            r_cause      <= HC_NONE;
            r_seed       <= '0;
            r_prev       <= '0;
`ifdef LIFE_CTRL_PERIOD2_EN
            r_prev2      <= '0;
`endif
            r_gen        <= '0;
            r_seed_we    <= 1'b0;
            r_step_en    <= 1'b0;
            r_eval_pend  <= 1'b0;
            r_pause_pend <= 1'b0;
            r_ld_ready   <= 1'b1;
        end else begin
            r_seed_we   <= 1'b0;
            r_step_en   <= 1'b0;
            r_eval_pend <= r_step_en;

            // The matrix still holds the pre-step generation during the step cycle.
            if (r_step_en) begin
                r_prev  <= i_grid_q;
`ifdef LIFE_CTRL_PERIOD2_EN
                r_prev2 <= r_prev;
`endif
            end

            if (r_eval_pend) begin
                if (r_gen != {GEN_W{1'b1}}) begin
                    r_gen <= r_gen + GEN_W'(1);
                end
                if (w_halt_hit) begin
                    r_cause <= w_hit_cause;
                end
            end

            case (r_state)
                ST_IDLE: begin
                    if (i_ld_valid && r_ld_ready) begin
                        r_seed[w_row_base +: N] <= i_ld_data;
                    end
                    if (w_start_ok) begin
                        r_state    <= ST_RUN;
                        r_ld_ready <= 1'b0;
                        r_seed_we  <= 1'b1;
                        r_gen      <= '0;
                        r_cause    <= HC_NONE;
                        r_prev     <= '0;
`ifdef LIFE_CTRL_PERIOD2_EN
                        r_prev2    <= '0;
`endif
                    end
                end
                ST_RUN: begin
                    // A pause seen during the step cycle waits for that evaluation.
                    if (r_step_en) begin
                        r_pause_pend <= w_pause_req;
                    end else begin
                        r_pause_pend <= 1'b0;
                        if (w_halt_hit) begin
                            r_state <= ST_HALT;
                        end else if (w_pause_req) begin
                            r_state <= ST_PAUSE;
                        end else begin
                            r_step_en <= w_tick;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (w_halt_hit) begin
                        r_state <= ST_HALT;
                    end else if (i_cmd_step && !w_busy) begin
                        r_step_en <= 1'b1;
                    end else if (w_start_ok) begin
                        r_state <= ST_RUN;
                    end
                end
                ST_HALT: begin
                    if (w_start_ok) begin
                        r_state <= ST_RUN;
                        r_cause <= HC_NONE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_ld_ready   = r_ld_ready;
    assign o_seed       = r_seed;
    assign o_seed_we    = r_seed_we;
    assign o_step_en    = r_step_en;
    assign o_gen_count  = r_gen;
    assign o_state      = r_state;
    assign o_halt_cause = r_cause;

endmodule
